// File: rtl/cfg_vpd_loader.sv
// Loads subsystem IDs and the device serial number from a 16-byte VPD record in byte-wide storage.
// Optional CFG_VPD_RELOAD_EN lets a reload pulse in DONE restart the fetch.
module cfg_vpd_loader #(
    parameter int                ADDR_W               = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR            = 16'h0000,
    parameter int                TIMEOUT_CYCLES       = 1024,
    parameter logic [15:0]       MAGIC                = 16'h4F43,
    parameter logic [15:0]       DEF_SUBSYS_ID        = 16'h0666,
    parameter logic [15:0]       DEF_SUBSYS_VENDOR_ID = 16'h1014,
    parameter logic [63:0]       DEF_SERIAL           = 64'hDEAD_DEAD_DEAD_DEAD
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    input  logic              rd_err,
    input  logic              reload,
    output logic [15:0]       f0_ro_csh_subsystem_id,
    output logic [15:0]       f0_ro_csh_subsystem_vendor_id,
    output logic [63:0]       f0_ro_dsn_serial_number,
    output logic [15:0]       f1_ro_csh_subsystem_id,
    output logic [15:0]       f1_ro_csh_subsystem_vendor_id,
    output logic              vpd_done,
    output logic              vpd_valid,
    output logic [1:0]        vpd_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, REQ, NEXT, CHECK, DONE} state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shadow [16];
    logic [7:0]       csum;
    logic             record_ok;

    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < 16; i++) csum = csum + shadow[i];
    end

    assign record_ok = ({shadow[0], shadow[1]} == MAGIC) && (csum == 8'h00);

    // Function 1 carries the same card identity as function 0.
    assign f1_ro_csh_subsystem_id        = f0_ro_csh_subsystem_id;
    assign f1_ro_csh_subsystem_vendor_id = f0_ro_csh_subsystem_vendor_id;

`ifndef CFG_VPD_RELOAD_EN
    logic unused_reload;
    assign unused_reload = reload;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                         <= IDLE;
            rd_req                        <= 1'b0;
            rd_addr                       <= BASE_ADDR;
            idx                           <= 4'd0;
            cnt                           <= '0;
            f0_ro_csh_subsystem_id        <= DEF_SUBSYS_ID;
            f0_ro_csh_subsystem_vendor_id <= DEF_SUBSYS_VENDOR_ID;
            f0_ro_dsn_serial_number       <= DEF_SERIAL;
            vpd_done                      <= 1'b0;
            vpd_valid                     <= 1'b0;
            vpd_error                     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    rd_req <= 1'b1;
                    state  <= REQ;
                end
                REQ: begin
                    if (rd_ack && !rd_err) begin
                        shadow[idx] <= rd_data;
                        rd_req      <= 1'b0;
                        state       <= NEXT;
                    end else if (rd_ack || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Any failed fetch drops back to the tie-off identity.
                        rd_req                        <= 1'b0;
                        vpd_error                     <= rd_ack ? 2'b10 : 2'b01;
                        vpd_valid                     <= 1'b0;
                        f0_ro_csh_subsystem_id        <= DEF_SUBSYS_ID;
                        f0_ro_csh_subsystem_vendor_id <= DEF_SUBSYS_VENDOR_ID;
                        f0_ro_dsn_serial_number       <= DEF_SERIAL;
                        state                         <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    cnt <= '0;
                    if (idx == 4'd15) begin
                        state <= CHECK;
                    end else begin
                        idx     <= idx + 4'd1;
                        rd_addr <= BASE_ADDR + ADDR_W'(idx + 4'd1);
                        rd_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                CHECK: begin
                    if (record_ok) begin
                        f0_ro_csh_subsystem_id        <= {shadow[2], shadow[3]};
                        f0_ro_csh_subsystem_vendor_id <= {shadow[4], shadow[5]};
                        f0_ro_dsn_serial_number       <= {shadow[6], shadow[7], shadow[8], shadow[9],
                                                          shadow[10], shadow[11], shadow[12], shadow[13]};
                        vpd_valid                     <= 1'b1;
                        vpd_error                     <= 2'b00;
                    end else begin
                        f0_ro_csh_subsystem_id        <= DEF_SUBSYS_ID;
                        f0_ro_csh_subsystem_vendor_id <= DEF_SUBSYS_VENDOR_ID;
                        f0_ro_dsn_serial_number       <= DEF_SERIAL;
                        vpd_valid                     <= 1'b0;
                        vpd_error                     <= 2'b11;
                    end
                    state <= DONE;
                end
                DONE: begin
                    vpd_done <= 1'b1;
                    rd_req   <= 1'b0;
`ifdef CFG_VPD_RELOAD_EN
                    // Committed outputs stay visible while the record is refetched.
                    if (reload) begin
                        vpd_done  <= 1'b0;
                        vpd_error <= 2'b00;
                        idx       <= 4'd0;
                        cnt       <= '0;
                        rd_addr   <= BASE_ADDR;
                        rd_req    <= 1'b1;
                        state     <= REQ;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_vpd_loader.sv
// Randomized bench for cfg_vpd_loader: storage responder plus a record-level reference model.
module tb_cfg_vpd_loader;

    localparam logic [15:0] BASE = 16'hFFF8;
    localparam int          TMO  = 16;
    localparam logic [15:0] DEF_SUB = 16'h0666;
    localparam logic [15:0] DEF_VEN = 16'h1014;
    localparam logic [63:0] DEF_SER = 64'hDEAD_DEAD_DEAD_DEAD;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_ack = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_err = 1'b0;
    logic        reload = 1'b0;
    logic [15:0] f0_sub, f0_ven, f1_sub, f1_ven;
    logic [63:0] f0_ser;
    logic        vpd_done, vpd_valid;
    logic [1:0]  vpd_error;

    cfg_vpd_loader #(.ADDR_W(16), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err), .reload(reload),
        .f0_ro_csh_subsystem_id(f0_sub), .f0_ro_csh_subsystem_vendor_id(f0_ven),
        .f0_ro_dsn_serial_number(f0_ser), .f1_ro_csh_subsystem_id(f1_sub),
        .f1_ro_csh_subsystem_vendor_id(f1_ven), .vpd_done(vpd_done),
        .vpd_valid(vpd_valid), .vpd_error(vpd_error)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rec [16];
    int  wait_max = 0;
    int  noack_byte = -1;
    int  err_byte = -1;
    bit  stray = 1'b0;

    logic        exp_valid;
    logic [1:0]  exp_err;
    logic [15:0] exp_sub, exp_ven;
    logic [63:0] exp_ser;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Storage model: acks after a random number of waits, supports a silent byte and an error byte.
    initial begin
        int waitcnt = 0;
        int cur_wait = 0;
        logic [15:0] off;
        forever begin
            @(negedge clock);
            #1;
            off = rd_addr - BASE;
            if (stray) begin
                rd_ack = 1'b1; rd_data = 8'hFF; rd_err = 1'b0; waitcnt = 0;
            end else if (rd_req && int'(off) != noack_byte && waitcnt >= cur_wait) begin
                rd_ack = 1'b1; rd_data = rec[off[3:0]]; rd_err = (int'(off) == err_byte);
            end else begin
                rd_ack = 1'b0; rd_data = 8'($urandom); rd_err = 1'($urandom);
                if (rd_req) waitcnt++;
                else begin
                    waitcnt = 0;
                    cur_wait = $urandom_range(0, wait_max);
                end
            end
        end
    end

    task automatic make_record(input logic [15:0] sub, input logic [15:0] ven, input logic [63:0] ser);
        int s;
        rec[0] = 8'h4F; rec[1] = 8'h43;
        rec[2] = sub[15:8]; rec[3] = sub[7:0];
        rec[4] = ven[15:8]; rec[5] = ven[7:0];
        for (int i = 0; i < 8; i++) rec[6 + i] = 8'((ser >> (56 - 8 * i)) & 64'hFF);
        rec[14] = 8'($urandom);
        s = 0;
        for (int i = 0; i < 15; i++) s += int'(rec[i]);
        rec[15] = 8'((256 - (s % 256)) % 256);
    endtask

    task automatic model();
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(rec[i]);
        exp_valid = 1'b0; exp_sub = DEF_SUB; exp_ven = DEF_VEN; exp_ser = DEF_SER;
        if (noack_byte >= 0)      exp_err = 2'b01;
        else if (err_byte >= 0)   exp_err = 2'b10;
        else if (int'(rec[0]) * 256 + int'(rec[1]) != 16'h4F43 || s % 256 != 0) exp_err = 2'b11;
        else begin
            exp_err = 2'b00; exp_valid = 1'b1;
            exp_sub = 16'(int'(rec[2]) * 256 + int'(rec[3]));
            exp_ven = 16'(int'(rec[4]) * 256 + int'(rec[5]));
            exp_ser = 64'h0;
            for (int i = 6; i < 14; i++) exp_ser = exp_ser * 256 + 64'(rec[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 2000) begin
            @(negedge clock);
            if (vpd_done) break;
            cycles++;
        end
        if (cycles >= 2000) check("done_bound", 64'd0, 64'd1);
    endtask

    task automatic check_outputs(input string tag);
        model();
        check({tag, "_done"},  64'(vpd_done),  64'd1);
        check({tag, "_valid"}, 64'(vpd_valid), 64'(exp_valid));
        check({tag, "_err"},   64'(vpd_error), 64'(exp_err));
        check({tag, "_f0sub"}, 64'(f0_sub),    64'(exp_sub));
        check({tag, "_f0ven"}, 64'(f0_ven),    64'(exp_ven));
        check({tag, "_f0ser"}, f0_ser,         exp_ser);
        check({tag, "_f1sub"}, 64'(f1_sub),    64'(exp_sub));
        check({tag, "_f1ven"}, 64'(f1_ven),    64'(exp_ven));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int hi;
        bit bad;
        logic [15:0] a_sub;
        logic [63:0] a_ser;

        // Reset values while reset_n is held low.
        make_record(16'h0777, 16'h1014, 64'h0123456789ABCDEF);
        repeat (3) @(negedge clock);
        check("rst_req",   64'(rd_req),    64'd0);
        check("rst_addr",  64'(rd_addr),   64'(BASE));
        check("rst_done",  64'(vpd_done),  64'd0);
        check("rst_valid", 64'(vpd_valid), 64'd0);
        check("rst_err",   64'(vpd_error), 64'd0);
        check("rst_sub",   64'(f0_sub),    64'(DEF_SUB));
        check("rst_ser",   f0_ser,         DEF_SER);

        // Directed valid record, zero-wait storage.
        reset_n = 1'b1;
        wait_done(cyc);
        check("valid_latency", 64'(cyc), 64'd34);
        check_outputs("valid");
        check("valid_sub_lit", 64'(f1_sub), 64'h0777);

        // Checksum byte off by one.
        rec[15] = rec[15] + 8'd1;
        do_reset(); wait_done(cyc);
        check_outputs("badsum");

        // No ack on byte 5: request held 16 cycles with a frozen address.
        make_record(16'h0777, 16'h1014, 64'h0123456789ABCDEF);
        noack_byte = 5;
        do_reset();
        hi = 0; bad = 1'b0;
        while (hi < 200) begin
            @(negedge clock);
            hi++;
            if (rd_req && rd_addr == BASE + 16'd5) break;
        end
        hi = 0;
        while (rd_req && hi < 200) begin
            if (rd_addr != BASE + 16'd5) bad = 1'b1;
            hi++;
            @(negedge clock);
        end
        check("tmo_req_cycles", 64'(hi), 64'd16);
        check("tmo_addr_frozen", 64'(bad), 64'd0);
        wait_done(cyc);
        check_outputs("tmo");
        noack_byte = -1;

        // Bus error on byte 9, no further requests afterwards.
        err_byte = 9;
        do_reset(); wait_done(cyc);
        check_outputs("buserr");
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (rd_req) bad = 1'b1;
        end
        check("buserr_no_req", 64'(bad), 64'd0);
        err_byte = -1;

        // Reset during byte 7, with a stray ack held across reset and IDLE.
        make_record(16'h1234, 16'hABCD, 64'hFEDCBA9876543210);
        do_reset();
        hi = 0;
        while (hi < 200) begin
            @(negedge clock);
            hi++;
            if (rd_req && rd_addr == BASE + 16'd7) break;
        end
        reset_n = 1'b0; stray = 1'b1;
        @(negedge clock);
        check("midrst_req", 64'(rd_req), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        check("midrst_restart_req",  64'(rd_req),  64'd1);
        check("midrst_restart_addr", 64'(rd_addr), 64'(BASE));
        wait_done(cyc);
        check_outputs("midrst");

        // Randomized records, corruptions and wait states.
        wait_max = 3;
        for (int it = 0; it < 20; it++) begin
            int mode;
            make_record(16'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
            mode = $urandom_range(0, 4);
            case (mode)
                1: rec[$urandom_range(0, 1)] ^= 8'($urandom_range(1, 255));
                2: rec[$urandom_range(2, 15)] += 8'($urandom_range(1, 255));
                3: noack_byte = $urandom_range(0, 15);
                4: err_byte = $urandom_range(0, 15);
                default: ;
            endcase
            do_reset(); wait_done(cyc);
            check_outputs($sformatf("rnd%0d", it));
            noack_byte = -1; err_byte = -1;
        end

        // Reload pulse after a valid load, with storage now holding a bad record.
        wait_max = 0;
        make_record(16'h0777, 16'h1014, 64'h0123456789ABCDEF);
        do_reset(); wait_done(cyc);
        a_sub = f0_sub; a_ser = f0_ser;
        check("pre_reload_valid", 64'(vpd_valid), 64'd1);
        rec[0] = 8'h00;
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
`ifdef CFG_VPD_RELOAD_EN
        check("reload_done_clr", 64'(vpd_done), 64'd0);
        check("reload_req", 64'(rd_req), 64'd1);
        bad = 1'b0; hi = 0;
        while (!vpd_done && hi < 200) begin
            if (vpd_error != 2'b11 && (f0_sub != a_sub || f0_ser != a_ser || !vpd_valid)) bad = 1'b1;
            hi++;
            @(negedge clock);
        end
        check("reload_held", 64'(bad), 64'd0);
        check_outputs("reload");
`else
        bad = 1'b0;
        repeat (40) begin
            if (rd_req || !vpd_done) bad = 1'b1;
            @(negedge clock);
        end
        check("noreload_idle", 64'(bad), 64'd0);
        check("noreload_sub", 64'(f0_sub), 64'(a_sub));
        check("noreload_valid", 64'(vpd_valid), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_vpd_loader.md
Name: cfg_vpd_loader

Overview:
- Supplies the card-specific read-only config fields: subsystem ID, subsystem vendor ID and device serial number.
- After reset, fetches a 16-byte VPD record from a byte-wide storage port and checks its magic and checksum.
- Drives the loaded values directly into the cfg_func0/cfg_func1 RO inputs, replacing fixed tie-off constants.
- If the record is missing or corrupt, falls back to parameter defaults.

Parameters:
ADDR_W, 16, storage address width
BASE_ADDR, 16'h0000, address of record byte 0
TIMEOUT_CYCLES, 1024, max cycles waiting for rd_ack per byte
MAGIC, 16'h4F43, required record bytes 0..1 (big-endian)
DEF_SUBSYS_ID, 16'h0666, fallback subsystem ID
DEF_SUBSYS_VENDOR_ID, 16'h1014, fallback subsystem vendor ID
DEF_SERIAL, 64'hDEAD_DEAD_DEAD_DEAD, fallback DSN

Ports:
clock  in  1  sole clock
reset_n  in  1  synchronous, active-low reset
rd_req  out  1  storage read request
rd_addr  out  ADDR_W  storage byte address
rd_ack  in  1  read complete; rd_data/rd_err valid
rd_data  in  8  returned byte
rd_err  in  1  storage error, qualified by rd_ack
reload  in  1  restart load pulse (see Optional Feature)
f0_ro_csh_subsystem_id  out  16  to cfg_func0
f0_ro_csh_subsystem_vendor_id  out  16  to cfg_func0
f0_ro_dsn_serial_number  out  64  to cfg_func0
f1_ro_csh_subsystem_id  out  16  to cfg_func1, always equal to f0 copy
f1_ro_csh_subsystem_vendor_id  out  16  to cfg_func1, always equal to f0 copy
vpd_done  out  1  load attempt finished
vpd_valid  out  1  outputs come from storage
vpd_error  out  2  00 none, 01 timeout, 10 bus error, 11 bad record

Behaviour:
- Record layout, big-endian:
  - bytes 0-1: magic
  - bytes 2-3: subsystem ID
  - bytes 4-5: subsystem vendor ID
  - bytes 6-13: serial number (byte 6 = bits 63:56)
  - byte 14: reserved
  - byte 15: checksum; the 8-bit sum of bytes 0..15 mod 256 must be 0x00
- Reset (reset_n=0 at an edge):
  - state=IDLE, rd_req=0, rd_addr=BASE_ADDR, byte index=0, timeout counter=0.
  - Data outputs = DEF_* values.
  - vpd_done=0, vpd_valid=0, vpd_error=00.
- States IDLE, REQ, NEXT, CHECK, DONE:
  - IDLE: advance to REQ unconditionally on the first cycle after reset deasserts.
  - REQ:
    - Drive rd_req=1, rd_addr=BASE_ADDR+index.
    - Address is held stable until rd_ack is sampled high.
    - On rd_ack=1, rd_err=0: capture rd_data into shadow byte [index], go to NEXT.
    - On rd_ack=1, rd_err=1: go to DONE, fail code 10.
    - If timeout counter reaches TIMEOUT_CYCLES-1 with no ack: go to DONE, fail code 01.
  - NEXT:
    - rd_req=0 for exactly one cycle; timeout counter cleared.
    - If index==15, go to CHECK; else index+1, go to REQ.
  - CHECK (one cycle):
    - Magic match and checksum==0: commit shadow to outputs in the same edge, vpd_valid=1, vpd_error=00.
    - Otherwise: outputs=DEF_*, vpd_valid=0, vpd_error=11.
    - Go to DONE.
  - DONE: vpd_done=1, rd_req=0; hold everything.
- Latency with a zero-wait ack:
  - Each byte costs REQ(1)+NEXT(1) = 2 cycles.
  - vpd_done rises 34 cycles after the IDLE→REQ transition.
- Output update rules:
  - Outputs never show partial records; they change only at CHECK or on a fail transition.
  - On a fail transition, outputs are forced to DEF_*.
- Boundary conditions:
  - rd_ack while not in REQ (IDLE, NEXT, CHECK, DONE): ignored.
  - Reset mid-load: immediate return to IDLE defaults; a later stray ack is ignored.
  - Timeout counter width: clog2(TIMEOUT_CYCLES).
  - rd_addr adds modulo 2^ADDR_W; it wraps silently.

Optional Feature:
- Macro: CFG_VPD_RELOAD_EN.
- Defined:
  - reload=1 sampled in DONE clears vpd_done, vpd_error and index, then goes to REQ.
  - During reload, outputs and vpd_valid keep their last committed values until the next CHECK or fail.
  - reload in any other state is ignored.
- Undefined: reload is ignored and the state machine stays in DONE until reset.

Test Plan:
- Valid record: magic 4F43, subsystem ID 0x0777, vendor ID 0x1014, serial 0x0123456789ABCDEF, checksum correct, ack after 0 waits -> vpd_done at cycle 34, vpd_valid=1, f0 and f1 subsystem ID 0x0777, serial 0x0123456789ABCDEF, vpd_error=00.
- Checksum byte off by 1 -> vpd_error=11, vpd_valid=0, outputs 0x0666/0x1014/0xDEADDEADDEADDEAD.
- Ack never returned for byte 5, TIMEOUT_CYCLES=16 -> rd_req drops after 16 cycles in REQ, vpd_error=01, defaults out, rd_addr frozen at BASE_ADDR+5 before the drop.
- rd_err=1 with ack on byte 9 -> vpd_error=10, no further rd_req, defaults out.
- reset_n low for 1 cycle during byte 7 -> rd_req=0 next cycle; load restarts at BASE_ADDR and completes valid; stray ack in IDLE is ignored.
- With CFG_VPD_RELOAD_EN: after a valid load, change storage to a bad record and pulse reload -> old values held while loading, then defaults and vpd_error=11. Without the macro, the same reload pulse causes no rd_req.
